// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit: instruction field layout,
// fetch FSM encodings and queue sizing helpers.
package instr_fetch_pkg;

  localparam int PC_W_DEFAULT    = 8;
  localparam int INSTR_W_DEFAULT = 8;

  localparam int OPCODE_W    = 5;
  localparam int OPERAND_W   = 3;
  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 3;
  localparam int OPERAND_MSB = 2;
  localparam int OPERAND_LSB = 0;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_REQ   = 2'd1;
  localparam logic [1:0] FS_FLUSH = 2'd2;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush and a registered head
// so consumers never see a combinational path from the push side.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_ptr_n;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_remain;
  logic [WIDTH-1:0] r_head;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop      = i_pop && (r_count != '0) && !i_flush;
  assign w_push     = i_push && !i_flush && ((r_count != FULL) || w_pop);
  assign w_rd_ptr_n = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  assign w_remain   = r_count - CNT_W'(w_pop);

  // NOTE: storage has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_remain + CNT_W'(w_push);
      // Head comes from storage unless the pushed byte becomes the only entry.
      if (w_remain != '0) begin
        r_head <= r_mem[w_rd_ptr_n];
      end else if (w_push) begin
        r_head <= i_push_data;
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests bytes from program memory, queues them and
// hands {opcode, operand, pc} to decode; execute redirects flush stale fetches.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT,
  parameter int DEPTH   = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [PC_W-1:0]      mem_addr,
  input  logic                 mem_ack,
  input  logic [INSTR_W-1:0]   mem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [OPERAND_W-1:0] operand,
  output logic [PC_W-1:0]      instr_pc,
  input  logic                 redirect_valid,
  input  logic [PC_W-1:0]      redirect_pc
);

  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int ENTRY_W = PC_W + INSTR_W;
  localparam logic [CNT_W-1:0] FULL        = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(DEPTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_n;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    w_fetch_pc_n;
  logic [PC_W-1:0]    r_addr;
  logic [PC_W-1:0]    w_addr_n;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_room_idle;
  logic               w_room_ack;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && instr_ready && !redirect_valid;
  assign w_push  = mem_ack && (r_state == FS_REQ) && !redirect_valid;

  // A request is only issued once a queue slot is guaranteed for its data.
  assign w_room_idle = w_pop || (w_count != FULL);
  assign w_room_ack  = w_pop || (w_count < ALMOST_FULL);

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    w_state_n    = r_state;
    w_fetch_pc_n = r_fetch_pc;
    w_addr_n     = r_addr;
    if (redirect_valid) begin
      w_fetch_pc_n = redirect_pc;
      if ((r_state != FS_IDLE) && !mem_ack) begin
        // The memory still owns the old request; keep its address until ack.
        w_state_n = FS_FLUSH;
      end else begin
        w_state_n = FS_REQ;
        w_addr_n  = redirect_pc;
      end
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (w_room_idle) begin
            w_state_n = FS_REQ;
            w_addr_n  = r_fetch_pc;
          end
        end
        FS_REQ: begin
          if (mem_ack) begin
            w_fetch_pc_n = r_fetch_pc + PC_W'(1);
            w_addr_n     = r_fetch_pc + PC_W'(1);
            w_state_n    = w_room_ack ? FS_REQ : FS_IDLE;
          end
        end
        FS_FLUSH: begin
          if (mem_ack) begin
            w_state_n = FS_REQ;
            w_addr_n  = r_fetch_pc;
          end
        end
        default: w_state_n = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FS_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_n;
      r_fetch_pc <= w_fetch_pc_n;
      r_addr     <= w_addr_n;
    end
  end

  instr_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({r_fetch_pc, mem_rdata}),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign mem_req     = (r_state != FS_IDLE);
  assign mem_addr    = r_addr;
  assign instr_valid = w_valid;
  assign instr_pc    = w_head[ENTRY_W-1:INSTR_W];
  assign opcode      = w_head[OPCODE_MSB:OPCODE_LSB];
  assign operand     = w_head[OPERAND_MSB:OPERAND_LSB];

endmodule
